id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of operands and results.
REQ-002 SHALL have parameter CNT_W, default 16, width of the bubble performance counter.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- IdRs, IdRt, IdRd  in  5 each  decoded register numbers.
- IdRsData, IdRtData  in  DATA_W each  register-file read data.
- IdImm  in  DATA_W  sign-extended immediate.
- IdShamt  in  5  shift amount.
- IdAluCtl  in  3  ALU control.
- IdAluSrc  in  1  1 = DataB takes the immediate.
- IdRegDst  in  1  1 = destination is Rd, 0 = Rt.
- IdUsesRt  in  1  instruction reads Rt.
- IdRegWrite, IdMemRead, IdMemWrite  in  1 each  control bits.
- Flush  in  1  kill the instruction currently in ID.
- ExMemRegWrite  in  1, ExMemRd  in  5, ExMemData  in  DATA_W  EX/MEM forwarding source.
- MemWbRegWrite  in  1, MemWbRd  in  5, MemWbData  in  DATA_W  MEM/WB forwarding source.
- Ctl  out  3, Shamt  out  5, DataA  out  DATA_W, DataB  out  DATA_W  ALU operands.
- ExRd  out  5  resolved destination register.
- ExRegWrite, ExMemRead, ExMemWrite  out  1 each  registered control.
- ExStoreData  out  DATA_W  forwarded Rt value for stores.
- Stall  out  1  hold PC and IF/ID.
- BubbleCount  out  CNT_W  bubbles inserted since reset.

Function
REQ-004 SHALL register all Id* fields into the EX stage on every rising clk edge unless a bubble is inserted (REQ-007).
REQ-005 SHALL register ExRd as IdRd when IdRegDst=1, else IdRt.
REQ-006 SHALL assert Stall combinationally when all of the following hold, and deassert it otherwise:
- ExMemRead=1;
- ExRd!=0;
- ExRd==IdRs, or (IdUsesRt=1 and ExRd==IdRt);
- Flush=0.
REQ-007 SHALL insert a bubble on any edge where Stall=1 or Flush=1.
- Bubble: RegWrite=0, MemRead=0, MemWrite=0, Ctl=000, ExRd=0.
- Data fields and register numbers of a bubble are 0.
REQ-008 SHALL let Flush take priority over the hazard: a bubble is inserted and Stall stays 0.
REQ-009 SHALL compute the forwarded Rs value combinationally from the registered Rs number and data, in this priority:
- ExMemData when ExMemRegWrite=1, ExMemRd!=0 and ExMemRd==Rs;
- else MemWbData when MemWbRegWrite=1, MemWbRd!=0 and MemWbRd==Rs;
- else the registered Rs data.
REQ-010 SHALL compute the forwarded Rt value by the same rule as REQ-009, applied to Rt.
REQ-011 SHALL drive DataA from the forwarded Rs value.
REQ-012 SHALL drive DataB from the registered immediate when AluSrc=1, else from the forwarded Rt value.
REQ-013 SHALL drive ExStoreData from the forwarded Rt value, regardless of AluSrc.
REQ-014 SHALL drive Ctl and Shamt directly from the registers: zero combinational logic between the register and the output.
REQ-015 SHALL increment BubbleCount by 1 on each edge that inserts a bubble, and saturate at all-ones with no wrap.
REQ-016 SHALL have a latency of exactly one cycle from Id* inputs to EX outputs; forwarding paths add no latency.

Reset
REQ-017 SHALL, on any edge with rst=1, clear every pipeline register and BubbleCount to 0, including when asserted mid-stall.
REQ-018 SHALL give rst priority over Flush and the hazard; BubbleCount does not increment on reset edges.
REQ-019 SHALL drive these outputs after reset: Stall=0, Ctl=0, DataA=0, DataB=0, ExRd=0, all control outputs 0, until new Id* data is captured.

Verification
REQ-020 SHALL pass a plain capture test: IdAluCtl=010, IdRsData=5, IdRtData=7, IdAluSrc=0, no hazards -> next cycle Ctl=010, DataA=5, DataB=7.
REQ-021 SHALL pass a forwarding-priority test: EX holds Rs=3; ExMemRd=3 with ExMemData=0xAA; MemWbRd=3 with MemWbData=0xBB; both RegWrite=1 -> DataA=0xAA. Same setup with ExMemRd=0 -> DataA=0xBB.
REQ-022 SHALL pass a load-use test: EX holds a load with ExRd=4; ID has IdRs=4 -> Stall=1; next cycle ExRegWrite=0 and BubbleCount=1; the ID instruction is held and captured the following cycle.
REQ-023 SHALL pass a flush-versus-hazard test: load-use condition present with Flush=1 -> Stall=0 and a bubble is inserted.
REQ-024 SHALL pass a counter-saturation test: preload by 2^CNT_W bubbles -> BubbleCount holds all-ones; then rst=1 for one cycle -> BubbleCount=0 and all outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: it detects load-use hazards, forwards operands from
// EX/MEM and MEM/WB, and keeps a saturating count of inserted bubbles.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        IdRs,
   input  logic [4:0]        IdRt,
   input  logic [4:0]        IdRd,
   input  logic [DATA_W-1:0] IdRsData,
   input  logic [DATA_W-1:0] IdRtData,
   input  logic [DATA_W-1:0] IdImm,
   input  logic [4:0]        IdShamt,
   input  logic [2:0]        IdAluCtl,
   input  logic              IdAluSrc,
   input  logic              IdRegDst,
   input  logic              IdUsesRt,
   input  logic              IdRegWrite,
   input  logic              IdMemRead,
   input  logic              IdMemWrite,
   input  logic              Flush,
   input  logic              ExMemRegWrite,
   input  logic [4:0]        ExMemRd,
   input  logic [DATA_W-1:0] ExMemData,
   input  logic              MemWbRegWrite,
   input  logic [4:0]        MemWbRd,
   input  logic [DATA_W-1:0] MemWbData,
   output logic [2:0]        Ctl,
   output logic [4:0]        Shamt,
   output logic [DATA_W-1:0] DataA,
   output logic [DATA_W-1:0] DataB,
   output logic [4:0]        ExRd,
   output logic              ExRegWrite,
   output logic              ExMemRead,
   output logic              ExMemWrite,
   output logic [DATA_W-1:0] ExStoreData,
   output logic              Stall,
   output logic [CNT_W-1:0]  BubbleCount
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [4:0]        r_rs, r_rt, r_rd, r_shamt;
   logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm;
   logic [2:0]        r_ctl;
   logic              r_alu_src, r_reg_write, r_mem_read, r_mem_write;
   logic [CNT_W-1:0]  r_bubble_cnt;

   logic              w_stall, w_bubble;
   logic [DATA_W-1:0] w_fwd_rs, w_fwd_rt;

   // A load in EX whose destination is read in ID must wait one cycle; a
   // flush kills the ID instruction anyway, so it masks the stall.
   assign w_stall  = r_mem_read && (r_rd != 5'd0) &&
                     ((r_rd == IdRs) || (IdUsesRt && (r_rd == IdRt))) && !Flush;
   assign w_bubble = w_stall || Flush;

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs -- no latch inferred.
      w_fwd_rs = r_rs_data;
      w_fwd_rt = r_rt_data;
      if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == r_rs))
         w_fwd_rs = ExMemData;
      else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == r_rs))
         w_fwd_rs = MemWbData;
      if (ExMemRegWrite && (ExMemRd != 5'd0) && (ExMemRd == r_rt))
         w_fwd_rt = ExMemData;
      else if (MemWbRegWrite && (MemWbRd != 5'd0) && (MemWbRd == r_rt))
         w_fwd_rt = MemWbData;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst || w_bubble) begin
         r_rs        <= '0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_shamt     <= '0;
         r_rs_data   <= '0;
         r_rt_data   <= '0;
         r_imm       <= '0;
         r_ctl       <= '0;
         r_alu_src   <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end else begin
         r_rs        <= IdRs;
         r_rt        <= IdRt;
         r_rd        <= IdRegDst ? IdRd : IdRt;
         r_shamt     <= IdShamt;
         r_rs_data   <= IdRsData;
         r_rt_data   <= IdRtData;
         r_imm       <= IdImm;
         r_ctl       <= IdAluCtl;
         r_alu_src   <= IdAluSrc;
         r_reg_write <= IdRegWrite;
         r_mem_read  <= IdMemRead;
         r_mem_write <= IdMemWrite;
      end
   end

   // Reset edges clear the count without counting themselves as bubbles.
   always_ff @(posedge clk) begin
      if (rst)
         r_bubble_cnt <= '0;
      else if (w_bubble && (r_bubble_cnt != '1))
         r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
   end

   assign Ctl         = r_ctl;
   assign Shamt       = r_shamt;
   assign DataA       = w_fwd_rs;
   assign DataB       = r_alu_src ? r_imm : w_fwd_rt;
   assign ExStoreData = w_fwd_rt;
   assign ExRd        = r_rd;
   assign ExRegWrite  = r_reg_write;
   assign ExMemRead   = r_mem_read;
   assign ExMemWrite  = r_mem_write;
   assign Stall       = w_stall;
   assign BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written
// stall/flush/reset/saturation sequences, and randomized traffic against a model.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int CW = 6;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    IdRs, IdRt, IdRd, IdShamt;
   logic [DW-1:0] IdRsData, IdRtData, IdImm;
   logic [2:0]    IdAluCtl;
   logic          IdAluSrc, IdRegDst, IdUsesRt, IdRegWrite, IdMemRead, IdMemWrite, Flush;
   logic          ExMemRegWrite, MemWbRegWrite;
   logic [4:0]    ExMemRd, MemWbRd;
   logic [DW-1:0] ExMemData, MemWbData;
   logic [2:0]    Ctl;
   logic [4:0]    Shamt, ExRd;
   logic [DW-1:0] DataA, DataB, ExStoreData;
   logic          ExRegWrite, ExMemRead, ExMemWrite, Stall;
   logic [CW-1:0] BubbleCount;

   id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
      .IdRsData(IdRsData), .IdRtData(IdRtData), .IdImm(IdImm),
      .IdShamt(IdShamt), .IdAluCtl(IdAluCtl), .IdAluSrc(IdAluSrc),
      .IdRegDst(IdRegDst), .IdUsesRt(IdUsesRt),
      .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
      .Flush(Flush),
      .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemData(ExMemData),
      .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
      .Ctl(Ctl), .Shamt(Shamt), .DataA(DataA), .DataB(DataB), .ExRd(ExRd),
      .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
      .ExStoreData(ExStoreData), .Stall(Stall), .BubbleCount(BubbleCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]    rs, rt, rd, shamt;
      logic [DW-1:0] rs_data, rt_data, imm;
      logic [2:0]    ctl;
      logic          alu_src, reg_dst, uses_rt, rw, mr, mw, flush;
      logic          xm_rw;
      logic [4:0]    xm_rd;
      logic [DW-1:0] xm_data;
      logic          wb_rw;
      logic [4:0]    wb_rd;
      logic [DW-1:0] wb_data;
   } stim_t;

   // Contents of the EX stage as the model sees them.
   typedef struct packed {
      logic [4:0]    rs, rt, rd, shamt;
      logic [DW-1:0] rs_data, rt_data, imm;
      logic [2:0]    ctl;
      logic          alu_src, rw, mr, mw;
   } ex_t;

   typedef struct {
      stim_t         in;
      logic          stall;
      logic [2:0]    ctl;
      logic [4:0]    shamt;
      logic [DW-1:0] a, b, store;
      logic [4:0]    rd;
      logic          rw, mr, mw;
      logic [CW-1:0] cnt;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t mk(input logic [4:0] rs, rt, rd,
                                input logic [DW-1:0] rs_data, rt_data, imm,
                                input logic [2:0] ctl,
                                input logic alu_src, reg_dst, uses_rt, rw, mr, mw, flush,
                                input logic [4:0] shamt);
      stim_t s = '0;
      s.rs = rs; s.rt = rt; s.rd = rd;
      s.rs_data = rs_data; s.rt_data = rt_data; s.imm = imm; s.ctl = ctl;
      s.alu_src = alu_src; s.reg_dst = reg_dst; s.uses_rt = uses_rt;
      s.rw = rw; s.mr = mr; s.mw = mw; s.flush = flush; s.shamt = shamt;
      return s;
   endfunction

   function automatic stim_t fw(input stim_t s_in, input logic xm_rw, input logic [4:0] xm_rd,
                                input logic [DW-1:0] xm_data, input logic wb_rw,
                                input logic [4:0] wb_rd, input logic [DW-1:0] wb_data);
      stim_t s = s_in;
      s.xm_rw = xm_rw; s.xm_rd = xm_rd; s.xm_data = xm_data;
      s.wb_rw = wb_rw; s.wb_rd = wb_rd; s.wb_data = wb_data;
      return s;
   endfunction

   function automatic vec_t mkv(input stim_t in, input logic stall, input logic [2:0] ctl,
                                input logic [4:0] shamt, input logic [DW-1:0] a, b, store,
                                input logic [4:0] rd, input logic rw, mr, mw,
                                input logic [CW-1:0] cnt);
      vec_t v;
      v.in = in; v.stall = stall; v.ctl = ctl; v.shamt = shamt;
      v.a = a; v.b = b; v.store = store; v.rd = rd;
      v.rw = rw; v.mr = mr; v.mw = mw; v.cnt = cnt;
      return v;
   endfunction

   task automatic drive(input stim_t s);
      IdRs = s.rs; IdRt = s.rt; IdRd = s.rd; IdShamt = s.shamt;
      IdRsData = s.rs_data; IdRtData = s.rt_data; IdImm = s.imm;
      IdAluCtl = s.ctl; IdAluSrc = s.alu_src; IdRegDst = s.reg_dst; IdUsesRt = s.uses_rt;
      IdRegWrite = s.rw; IdMemRead = s.mr; IdMemWrite = s.mw; Flush = s.flush;
      ExMemRegWrite = s.xm_rw; ExMemRd = s.xm_rd; ExMemData = s.xm_data;
      MemWbRegWrite = s.wb_rw; MemWbRd = s.wb_rd; MemWbData = s.wb_data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input vec_t v);
      check({tag, " Ctl"}, Ctl, v.ctl);
      check({tag, " Shamt"}, Shamt, v.shamt);
      check({tag, " DataA"}, DataA, v.a);
      check({tag, " DataB"}, DataB, v.b);
      check({tag, " ExStoreData"}, ExStoreData, v.store);
      check({tag, " ExRd"}, ExRd, v.rd);
      check({tag, " ExRegWrite"}, ExRegWrite, v.rw);
      check({tag, " ExMemRead"}, ExMemRead, v.mr);
      check({tag, " ExMemWrite"}, ExMemWrite, v.mw);
      check({tag, " BubbleCount"}, BubbleCount, v.cnt);
   endtask

   // Behavioural reference: forwarding picks the youngest writer of a nonzero register.
   function automatic logic [DW-1:0] fwd_val(input stim_t s, input logic [4:0] r,
                                             input logic [DW-1:0] d);
      if (s.xm_rw && s.xm_rd != 0 && s.xm_rd == r) return s.xm_data;
      if (s.wb_rw && s.wb_rd != 0 && s.wb_rd == r) return s.wb_data;
      return d;
   endfunction

   function automatic logic hazard(input stim_t s, input ex_t e);
      logic reads_load = (e.rd == s.rs) || (s.uses_rt && (e.rd == s.rt));
      return e.mr && (e.rd != 0) && reads_load && !s.flush;
   endfunction

   vec_t  vecs[10];
   stim_t cur;
   ex_t   m_ex;
   int    m_bubbles;
   vec_t  exp_v;
   logic  m_stall, do_rst;

   initial begin
      vecs[0] = mkv(mk(1, 2, 3, 5, 7, 0, 3'b010, 0, 1, 1, 1, 0, 0, 0, 4),
                    0, 3'b010, 4, 5, 7, 7, 3, 1, 0, 0, 0);
      vecs[1] = mkv(mk(5, 6, 7, 'h11, 'h22, 'hFFFF_FFF0, 3'b110, 1, 0, 1, 1, 0, 0, 0, 31),
                    0, 3'b110, 31, 'h11, 'hFFFF_FFF0, 'h22, 6, 1, 0, 0, 0);
      vecs[2] = mkv(fw(mk(3, 9, 10, 1, 2, 0, 3'b001, 0, 1, 1, 1, 0, 0, 0, 0), 1, 3, 'hAA, 1, 3, 'hBB),
                    0, 3'b001, 0, 'hAA, 2, 2, 10, 1, 0, 0, 0);
      vecs[3] = mkv(fw(mk(3, 9, 10, 1, 2, 0, 3'b001, 0, 1, 1, 1, 0, 0, 0, 0), 1, 0, 'hAA, 1, 3, 'hBB),
                    0, 3'b001, 0, 'hBB, 2, 2, 10, 1, 0, 0, 0);
      vecs[4] = mkv(fw(mk(4, 8, 0, 'h44, 'h55, 0, 3'b000, 0, 0, 1, 1, 1, 0, 0, 0), 0, 8, 'hDD, 1, 8, 'hCC),
                    0, 3'b000, 0, 'h44, 'hCC, 'hCC, 8, 1, 1, 0, 0);
      vecs[5] = mkv(fw(mk(1, 2, 0, 'h31, 'h77, 'h10, 3'b010, 1, 0, 1, 0, 0, 1, 0, 0), 1, 2, 'h99, 0, 0, 0),
                    0, 3'b010, 0, 'h31, 'h10, 'h99, 2, 0, 0, 1, 0);
      vecs[6] = mkv(fw(mk(0, 8, 9, 5, 6, 0, 3'b011, 0, 1, 0, 1, 0, 0, 0, 0), 1, 0, 'hEE, 1, 0, 'hFF),
                    0, 3'b011, 0, 5, 6, 6, 9, 1, 0, 0, 0);
      vecs[7] = mkv(mk(2, 8, 0, 1, 2, 0, 3'b000, 0, 0, 1, 1, 1, 0, 0, 0),
                    0, 3'b000, 0, 1, 2, 2, 8, 1, 1, 0, 0);
      vecs[8] = mkv(mk(3, 8, 11, 'h30, 'h80, 0, 3'b101, 0, 1, 0, 1, 0, 0, 0, 0),
                    0, 3'b101, 0, 'h30, 'h80, 'h80, 11, 1, 0, 0, 0);
      vecs[9] = mkv(mk(6, 7, 12, 'h60, 'h70, 1, 3'b010, 1, 1, 1, 1, 1, 1, 1, 3),
                    0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset state
      drive('0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("reset Stall", Stall, 0);
      check_outs("reset", mkv('0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].in);
         #1;
         check($sformatf("vec%0d Stall", i), Stall, vecs[i].stall);
         step();
         check_outs($sformatf("vec%0d", i), vecs[i]);
      end

      // Load-use: one bubble, then the held ID instruction is captured
      drive(mk(1, 4, 0, 0, 0, 0, 3'b010, 1, 0, 1, 1, 1, 0, 0, 0));
      step();
      drive(mk(4, 5, 6, 'h123, 'h5, 0, 3'b100, 0, 1, 1, 1, 0, 0, 0, 0));
      #1;
      check("loaduse Stall", Stall, 1);
      step();
      check("loaduse bubble ExRegWrite", ExRegWrite, 0);
      check("loaduse bubble ExMemRead", ExMemRead, 0);
      check("loaduse bubble ExRd", ExRd, 0);
      check("loaduse bubble BubbleCount", BubbleCount, 2);
      check("loaduse bubble Stall", Stall, 0);
      step();
      check("loaduse capture ExRd", ExRd, 6);
      check("loaduse capture Ctl", Ctl, 3'b100);
      check("loaduse capture DataA", DataA, 'h123);
      check("loaduse capture ExRegWrite", ExRegWrite, 1);
      check("loaduse capture BubbleCount", BubbleCount, 2);

      // Rt hazard gated by IdUsesRt, then flush beats the hazard
      drive(mk(1, 5, 0, 0, 0, 0, 3'b010, 1, 0, 1, 1, 1, 0, 0, 0));
      step();
      drive(mk(1, 5, 7, 0, 0, 0, 3'b001, 0, 1, 1, 1, 0, 0, 0, 0));
      #1;
      check("rt hazard Stall", Stall, 1);
      IdUsesRt = 1'b0;
      #1;
      check("rt unused Stall", Stall, 0);
      IdUsesRt = 1'b1;
      Flush = 1'b1;
      #1;
      check("flush vs hazard Stall", Stall, 0);
      step();
      check("flush vs hazard ExRegWrite", ExRegWrite, 0);
      check("flush vs hazard ExRd", ExRd, 0);
      check("flush vs hazard BubbleCount", BubbleCount, 3);

      // Reset in the middle of a stall
      drive(mk(1, 4, 0, 0, 0, 0, 3'b010, 1, 0, 1, 1, 1, 0, 0, 0));
      step();
      drive(mk(4, 2, 3, 'h9, 'h8, 0, 3'b111, 0, 1, 1, 1, 0, 0, 0, 0));
      #1;
      check("midstall Stall", Stall, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midstall rst Stall", Stall, 0);
      check_outs("midstall rst", mkv('0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Counter saturation, then reset clears it
      drive(mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < CNT_MAX; i++) step();
      check("sat reach BubbleCount", BubbleCount, CNT_MAX);
      step();
      check("sat hold1 BubbleCount", BubbleCount, CNT_MAX);
      step();
      check("sat hold2 BubbleCount", BubbleCount, CNT_MAX);
      drive('0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("sat rst Stall", Stall, 0);
      check_outs("sat rst", mkv('0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Randomized traffic against the reference model
      m_ex = '0;
      m_bubbles = 0;
      m_stall = 1'b0;
      cur = '0;
      for (int n = 0; n < 800; n++) begin
         stim_t nxt;
         nxt = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 31)));
         if (m_stall) begin
            // upstream holds the stalled instruction; only flush and forwarding change
            nxt.rs = cur.rs; nxt.rt = cur.rt; nxt.rd = cur.rd; nxt.shamt = cur.shamt;
            nxt.rs_data = cur.rs_data; nxt.rt_data = cur.rt_data; nxt.imm = cur.imm;
            nxt.ctl = cur.ctl; nxt.alu_src = cur.alu_src; nxt.reg_dst = cur.reg_dst;
            nxt.uses_rt = cur.uses_rt; nxt.rw = cur.rw; nxt.mr = cur.mr; nxt.mw = cur.mw;
         end
         cur = fw(nxt, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         do_rst = ($urandom_range(0, 63) == 0);
         drive(cur);
         rst = do_rst;
         #2;
         m_stall = hazard(cur, m_ex);
         exp_v = mkv(cur, m_stall, m_ex.ctl, m_ex.shamt,
                     fwd_val(cur, m_ex.rs, m_ex.rs_data),
                     m_ex.alu_src ? m_ex.imm : fwd_val(cur, m_ex.rt, m_ex.rt_data),
                     fwd_val(cur, m_ex.rt, m_ex.rt_data),
                     m_ex.rd, m_ex.rw, m_ex.mr, m_ex.mw, CW'(m_bubbles));
         check($sformatf("rand%0d Stall", n), Stall, exp_v.stall);
         check_outs($sformatf("rand%0d", n), exp_v);
         @(posedge clk);
         if (do_rst) begin
            m_ex = '0;
            m_bubbles = 0;
         end else if (m_stall || cur.flush) begin
            m_ex = '0;
            if (m_bubbles < CNT_MAX) m_bubbles++;
         end else begin
            m_ex.rs = cur.rs; m_ex.rt = cur.rt; m_ex.rd = cur.reg_dst ? cur.rd : cur.rt;
            m_ex.shamt = cur.shamt; m_ex.rs_data = cur.rs_data; m_ex.rt_data = cur.rt_data;
            m_ex.imm = cur.imm; m_ex.ctl = cur.ctl; m_ex.alu_src = cur.alu_src;
            m_ex.rw = cur.rw; m_ex.mr = cur.mr; m_ex.mw = cur.mw;
         end
         if (do_rst) m_stall = 1'b0;
         #1;
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
